// File: rtl/mem_sram_ctrl.sv
// MEM-stage load/store responder for a 16-bit asynchronous SRAM.
// Each 32-bit access runs as two half-word phases with fixed wait states.
module mem_sram_ctrl #(
  parameter int unsigned BASE_ADDR   = 1024,
  parameter int unsigned WAIT_CYCLES = 5,
  parameter int unsigned SRAM_AW     = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic               rd_en,
  input  logic [31:0]        address,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_dq_o,
  input  logic [15:0]        sram_dq_i,
  output logic               sram_dq_oe,
  output logic               sram_ce_n,
  output logic               sram_we_n,
  output logic               sram_oe_n
);

  localparam int unsigned CW = $clog2(WAIT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic               op_wr;
  logic [SRAM_AW-1:0] lo_addr_q;
  logic [31:0]        wdata_q;

  logic [31:0]        offset_c;
  logic [SRAM_AW-1:0] lo_addr_c;
  logic [CW-1:0]      cnt_inc_c;
  logic               cnt_last_c;
  logic               req_c;
  logic               unused_ok;

  // Half-word index relative to the SRAM window; byte offset within the word is dropped
  assign offset_c   = address - 32'(BASE_ADDR);
  assign lo_addr_c  = {offset_c[SRAM_AW:2], 1'b0};
  assign cnt_inc_c  = cnt + CW'(1);
  assign cnt_last_c = (cnt == CNT_LAST);
  assign req_c      = wr_en | rd_en;
  assign unused_ok  = ^{offset_c[31:SRAM_AW+1], offset_c[1:0]};

  // Pipeline handshake: free when idle with no new request, or on the completion cycle
  assign ready = ((state == IDLE) & ~req_c) | (state == DONE);

  // Access sequencer with registered SRAM strobes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      op_wr      <= 1'b0;
      lo_addr_q  <= '0;
      wdata_q    <= '0;
      read_data  <= '0;
      sram_addr  <= '0;
      sram_dq_o  <= '0;
      sram_dq_oe <= 1'b0;
      sram_ce_n  <= 1'b1;
      sram_we_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (req_c) begin
            // Write wins when both requests are raised together
            op_wr      <= wr_en;
            lo_addr_q  <= lo_addr_c;
            wdata_q    <= write_data;
            state      <= LOW;
            cnt        <= '0;
            sram_addr  <= lo_addr_c;
            sram_ce_n  <= 1'b0;
            sram_dq_oe <= wr_en;
            sram_we_n  <= ~wr_en;
            sram_oe_n  <= wr_en;
            if (wr_en) sram_dq_o <= write_data[15:0];
          end
        end
        LOW, HIGH: begin
          if (cnt_last_c) begin
            cnt <= '0;
            if (state == LOW) begin
              if (!op_wr) read_data[15:0] <= sram_dq_i;
              state     <= HIGH;
              sram_addr <= lo_addr_q | SRAM_AW'(1);
              sram_we_n <= ~op_wr;
              if (op_wr) sram_dq_o <= wdata_q[31:16];
            end else begin
              if (!op_wr) read_data[31:16] <= sram_dq_i;
              state      <= DONE;
              sram_ce_n  <= 1'b1;
              sram_we_n  <= 1'b1;
              sram_oe_n  <= 1'b1;
              sram_dq_oe <= 1'b0;
            end
          end else begin
            cnt <= cnt_inc_c;
            // Release we_n one cycle early so address/data hold past the write strobe
            sram_we_n <= ~op_wr | (cnt_inc_c == CNT_LAST);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
